rifl_tx_frame_sched: RTL and testbench

- Transmit-side frame scheduler. Each frame boundary it picks one of: a forced idle frame, a control frame, a user data frame or an idle frame.
- It assembles the chosen FRAME_WIDTH-bit frame and serialises it MSB-first as FRAME_WIDTH/DWIDTH beats of DWIDTH bits, asserting sof on the first beat.
- Its output drives the CRC/frame-ID insertion stage directly, so the low CRC_WIDTH bits of every frame are left zero for that stage.

---
 rtl/rifl_tx_frame_sched.sv | 106 ++++++++++
 tb/tb_rifl_tx_frame_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rifl_tx_frame_sched.sv
// rifl_tx_frame_sched: transmit frame scheduler and MSB-first beat serialiser.
// Ports: clk/rst; s_data/s_valid/s_ready payload; ctrl_req/ctrl_code/ctrl_ack;
// remote_pause; sof/data_out beat stream; idle_forced pulse.
module rifl_tx_frame_sched #(
    parameter int FRAME_WIDTH = 256,
    parameter int DWIDTH      = 64,
    parameter int CRC_WIDTH   = 12,
    parameter int CTRL_WIDTH  = 8,
    parameter int IDLE_PERIOD = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FRAME_WIDTH-CRC_WIDTH-3:0] s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            ctrl_req,
    input  logic [CTRL_WIDTH-1:0]           ctrl_code,
    output logic                            ctrl_ack,
    input  logic                            remote_pause,
    output logic                            sof,
    output logic [DWIDTH-1:0]               data_out,
    output logic                            idle_forced
);
    localparam int BEATS = FRAME_WIDTH / DWIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (IDLE_PERIOD > 0) ? $clog2(IDLE_PERIOD + 1) : 1;
    localparam int CTRL_SHIFT = FRAME_WIDTH - 2 - CTRL_WIDTH;

    localparam logic [CW-1:0] LAST    = CW'(BEATS - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(IDLE_PERIOD);

    localparam logic [FRAME_WIDTH-1:0] HDR_DATA =
        {2'b01, {(FRAME_WIDTH-2){1'b0}}};
    localparam logic [FRAME_WIDTH-1:0] HDR_CTRL =
        {2'b10, {(FRAME_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_FORCE,
        SEL_CTRL,
        SEL_DATA
    } sel_e;

    logic [CW-1:0]          cnt;
    logic [RW-1:0]          run;
    logic [FRAME_WIDTH-1:0] sreg;
    logic                   boundary;
    logic                   force_idle;
    sel_e                   sel;
    logic [FRAME_WIDTH-1:0] word;

    always_comb begin
        boundary   = (cnt == LAST);
        force_idle = boundary && (IDLE_PERIOD != 0) && (run == RUN_MAX);
        ctrl_ack   = boundary && ctrl_req && !force_idle;
        s_ready    = boundary && !force_idle && !ctrl_req && !remote_pause;

        sel = SEL_IDLE;
        if (force_idle)
            sel = SEL_FORCE;
        else if (ctrl_ack)
            sel = SEL_CTRL;
        else if (s_valid && s_ready)
            sel = SEL_DATA;

        word = '0;
        case (sel)
            SEL_CTRL: word = HDR_CTRL | (FRAME_WIDTH'(ctrl_code) << CTRL_SHIFT);
            SEL_DATA: word = HDR_DATA | (FRAME_WIDTH'(s_data) << CRC_WIDTH);
            default:  word = '0;
        endcase
    end

    // The shift register holds the whole frame width; its top DWIDTH
    // bits are always the next beat to go out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= LAST;
            sof         <= 1'b0;
            data_out    <= '0;
            idle_forced <= 1'b0;
            run         <= '0;
            sreg        <= '0;
        end else if (boundary) begin
            cnt         <= '0;
            sof         <= 1'b1;
            data_out    <= word[FRAME_WIDTH-1 -: DWIDTH];
            sreg        <= word << DWIDTH;
            idle_forced <= force_idle;
            case (sel)
                SEL_CTRL, SEL_DATA: begin
                    if (run != RUN_MAX)
                        run <= run + RW'(1);
                end
                default: run <= '0;
            endcase
        end else begin
            cnt         <= cnt + CW'(1);
            sof         <= 1'b0;
            data_out    <= sreg[FRAME_WIDTH-1 -: DWIDTH];
            sreg        <= sreg << DWIDTH;
            idle_forced <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rifl_tx_frame_sched.sv
// tb_rifl_tx_frame_sched: bench for rifl_tx_frame_sched.
// Three instances: default, IDLE_PERIOD=4, and single-beat 64-bit frames.
module tb_rifl_tx_frame_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [241:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         ctrl_req = 1'b0;
    logic [7:0]   ctrl_code = '0;
    logic         pause = 1'b0;

    logic         s_ready0, ctrl_ack0, sof0, if0;
    logic [63:0]  data0;
    logic         s_ready1, ctrl_ack1, sof1, if1;
    logic [63:0]  data1;

    logic [49:0]  s_data2 = '0;
    logic         s_valid2 = 1'b0;
    logic         ctrl_req2 = 1'b0;
    logic [7:0]   ctrl_code2 = '0;
    logic         pause2 = 1'b0;
    logic         s_ready2, ctrl_ack2, sof2, if2;
    logic [63:0]  data2;

    rifl_tx_frame_sched dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .ctrl_req(ctrl_req), .ctrl_code(ctrl_code),
        .ctrl_ack(ctrl_ack0), .remote_pause(pause), .sof(sof0),
        .data_out(data0), .idle_forced(if0)
    );

    rifl_tx_frame_sched #(.IDLE_PERIOD(4)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .ctrl_req(ctrl_req), .ctrl_code(ctrl_code),
        .ctrl_ack(ctrl_ack1), .remote_pause(pause), .sof(sof1),
        .data_out(data1), .idle_forced(if1)
    );

    rifl_tx_frame_sched #(.FRAME_WIDTH(64), .DWIDTH(64), .IDLE_PERIOD(0)) dut2 (
        .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2),
        .s_ready(s_ready2), .ctrl_req(ctrl_req2), .ctrl_code(ctrl_code2),
        .ctrl_ack(ctrl_ack2), .remote_pause(pause2), .sof(sof2),
        .data_out(data2), .idle_forced(if2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level reference: each instance owns a queue of expected beats.
    typedef struct packed {
        logic        sof;
        logic        frc;
        logic [63:0] d;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    run0 = 0;
    int    run1 = 0;
    logic  last_r0, last_a0, last_r2, last_a2;

    function automatic void decide(input int ip, inout int run,
                                   output logic rdy, output logic ack,
                                   output logic frc,
                                   output logic [255:0] w);
        frc = (ip != 0) && (run == ip);
        ack = ctrl_req && !frc;
        rdy = !frc && !ctrl_req && !pause;
        if (frc) begin
            w = '0; run = 0;
        end else if (ack) begin
            w = {2'b10, ctrl_code, 246'b0};
            run = (run + 1 > ip) ? ip : run + 1;
        end else if (s_valid && rdy) begin
            w = {2'b01, s_data, 12'b0};
            run = (run + 1 > ip) ? ip : run + 1;
        end else begin
            w = '0; run = 0;
        end
    endfunction

    task automatic cycle();
        logic r, a, f;
        logic [255:0] w;
        beat_t b;
        @(negedge clk);
        r = 1'b0; a = 1'b0;
        if (q0.size() == 0) begin
            decide(1024, run0, r, a, f, w);
            for (int k = 0; k < 4; k++)
                q0.push_back('{k == 0, (k == 0) && f, w[255-64*k -: 64]});
        end
        chk("s_ready0", 64'(s_ready0), 64'(r));
        chk("ctrl_ack0", 64'(ctrl_ack0), 64'(a));
        last_r0 = s_ready0;
        last_a0 = ctrl_ack0;
        r = 1'b0; a = 1'b0;
        if (q1.size() == 0) begin
            decide(4, run1, r, a, f, w);
            for (int k = 0; k < 4; k++)
                q1.push_back('{k == 0, (k == 0) && f, w[255-64*k -: 64]});
        end
        chk("s_ready1", 64'(s_ready1), 64'(r));
        chk("ctrl_ack1", 64'(ctrl_ack1), 64'(a));
        last_r2 = s_ready2;
        last_a2 = ctrl_ack2;
        @(posedge clk);
        #1;
        b = q0.pop_front();
        chk("sof0", 64'(sof0), 64'(b.sof));
        chk("data0", data0, b.d);
        chk("idle_forced0", 64'(if0), 64'(b.frc));
        b = q1.pop_front();
        chk("sof1", 64'(sof1), 64'(b.sof));
        chk("data1", data1, b.d);
        chk("idle_forced1", 64'(if1), 64'(b.frc));
    endtask

    task automatic to_boundary();
        while (q0.size() != 0) cycle();
    endtask

    typedef struct {
        logic        v;
        logic [49:0] d;
        logic        c;
        logic [7:0]  code;
        logic        p;
        logic        er;
        logic        ea;
        logic [63:0] eo;
    } vec_t;

    vec_t tv[7];
    int   hdr_q[$];
    int   exp_hdr[10];
    int   nrdy, nack, nf0, nf1;
    logic [255:0] rnd;

    initial begin
        tv[0] = '{1'b1, 50'h3_FFFF_FFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,
                  64'h7FFF_FFFF_FFFF_F000};
        tv[1] = '{1'b1, 50'h1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1,
                  64'hA940_0000_0000_0000};
        tv[2] = '{1'b1, 50'h1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 64'h0};
        tv[3] = '{1'b1, 50'h1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,
                  64'h4000_0000_0000_1000};
        tv[4] = '{1'b0, 50'h1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 64'h0};
        tv[5] = '{1'b0, 50'h0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1,
                  64'h8F00_0000_0000_0000};
        tv[6] = '{1'b1, 50'h2_AAAA_AAAA_AAAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,
                  64'h6AAA_AAAA_AAAA_A000};
        exp_hdr = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sof0", 64'(sof0), 64'h0);
        chk("rst_data0", data0, 64'h0);
        chk("rst_if0", 64'(if0), 64'h0);
        chk("rst_sof2", 64'(sof2), 64'h0);
        chk("rst_data2", data2, 64'h0);
        rst = 1'b0;

        // idle after reset: first cycle is a boundary
        cycle();
        chk("first_ready", 64'(last_r0), 64'h1);
        repeat (7) cycle();

        // single all-ones data frame
        s_valid = 1'b1;
        s_data  = '1;
        cycle();
        s_valid = 1'b0;
        chk("d_beat0", data0, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("d_sof0", 64'(sof0), 64'h1);
        cycle();
        chk("d_beat1", data0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("d_sof1", 64'(sof0), 64'h0);
        cycle();
        chk("d_beat2", data0, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        chk("d_beat3", data0, 64'hFFFF_FFFF_FFFF_F000);

        // control and data together: control wins, data next boundary
        ctrl_req  = 1'b1;
        ctrl_code = 8'hA5;
        s_valid   = 1'b1;
        s_data    = 242'h123;
        cycle();
        chk("sim_ack", 64'(last_a0), 64'h1);
        chk("sim_ready", 64'(last_r0), 64'h0);
        chk("sim_beat0", data0, 64'hA940_0000_0000_0000);
        ctrl_req = 1'b0;
        repeat (3) cycle();
        cycle();
        chk("sim_data_ready", 64'(last_r0), 64'h1);
        chk("sim_data_beat0", data0, 64'h4000_0000_0000_0000);
        s_valid = 1'b0;
        repeat (3) cycle();

        // pause: no data, control still acked
        pause   = 1'b1;
        s_valid = 1'b1;
        s_data  = 242'h5A5A;
        nrdy = 0; nack = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin
                ctrl_req  = 1'b1;
                ctrl_code = 8'h3C;
            end
            cycle();
            nrdy += int'(last_r0);
            nack += int'(last_a0);
            if (last_a0) ctrl_req = 1'b0;
        end
        chk("pause_ready_cnt", 64'(nrdy), 64'h0);
        chk("pause_ack_cnt", 64'(nack), 64'h1);
        pause = 1'b0;
        cycle();
        chk("unpause_ready", 64'(last_r0), 64'h1);
        s_valid = 1'b0;
        to_boundary();

        // async reset in beat 2 of a data frame
        s_valid = 1'b1;
        s_data  = '1;
        cycle();
        s_valid = 1'b0;
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("ar_data0", data0, 64'h0);
        chk("ar_sof0", 64'(sof0), 64'h0);
        chk("ar_data1", data1, 64'h0);
        q0.delete(); q1.delete();
        run0 = 0; run1 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        chk("ar_fresh_ready", 64'(last_r0), 64'h1);
        chk("ar_fresh_sof", 64'(sof0), 64'h1);
        repeat (3) cycle();

        // forced idle with s_valid held (dut1 has IDLE_PERIOD=4)
        s_valid = 1'b1;
        s_data  = 242'hBEEF;
        nf0 = 0; nf1 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (sof1) hdr_q.push_back(int'(data1[63:62]));
            nf0 += int'(if0);
            nf1 += int'(if1);
        end
        s_valid = 1'b0;
        chk("force_frames", 64'(hdr_q.size()), 64'd10);
        for (int i = 0; i < 10 && i < hdr_q.size(); i++)
            chk($sformatf("force_hdr%0d", i), 64'(hdr_q[i]), 64'(exp_hdr[i]));
        chk("force_pulses1", 64'(nf1), 64'd2);
        chk("force_pulses0", 64'(nf0), 64'd0);

        // single-beat configuration, table-driven
        for (int i = 0; i < 7; i++) begin
            s_valid2   = tv[i].v;
            s_data2    = tv[i].d;
            ctrl_req2  = tv[i].c;
            ctrl_code2 = tv[i].code;
            pause2     = tv[i].p;
            cycle();
            chk($sformatf("tv%0d_ready", i), 64'(last_r2), 64'(tv[i].er));
            chk($sformatf("tv%0d_ack", i), 64'(last_a2), 64'(tv[i].ea));
            chk($sformatf("tv%0d_data", i), data2, tv[i].eo);
            chk($sformatf("tv%0d_sof", i), 64'(sof2), 64'h1);
        end
        s_valid2  = 1'b0;
        ctrl_req2 = 1'b0;

        // randomized traffic against the frame-level model
        for (int i = 0; i < 3000; i++) begin
            if (ctrl_req && last_a0)
                ctrl_req = 1'b0;
            else if (!ctrl_req && ($urandom_range(0, 7) == 0)) begin
                ctrl_req  = 1'b1;
                ctrl_code = 8'($urandom);
            end
            if (!s_valid || last_r0) begin
                s_valid = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 8; k++)
                    rnd[32*k +: 32] = $urandom;
                s_data = rnd[241:0];
            end
            if ($urandom_range(0, 15) == 0)
                pause = ~pause;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
